// File: rtl/irq_request_latch_if.sv
// irq_request_latch_if: offer handshake between the request latch and its consumer.
// Ports: irq_valid/irq_id (latch -> consumer), irq_ready (consumer -> latch).
interface irq_request_latch_if #(
  parameter int IDW = 2
);
  logic           irq_valid;
  logic [IDW-1:0] irq_id;
  logic           irq_ready;

  modport master (
    output irq_valid,
    output irq_id,
    input  irq_ready
  );

  modport slave (
    input  irq_valid,
    input  irq_id,
    output irq_ready
  );
endinterface

// File: rtl/irq_request_latch.sv
// irq_request_latch: synchronises request lines, latches rising edges into
// sticky pending bits and offers the highest pending index over valid/ready.
// Ports: clk, rst_n (async, active-low), req_in (async lines), mask,
// pend_out (pending & ~mask, encoder din), ovf (sticky overrun), ovf_clr,
// irq (master side of irq_request_latch_if: irq_valid, irq_id, irq_ready).
module irq_request_latch #(
  parameter int N           = 4,
  parameter int IDW         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  input  logic [N-1:0] mask,
  output logic [N-1:0] pend_out,
  output logic [N-1:0] ovf,
  input  logic         ovf_clr,
  irq_request_latch_if.master irq
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [N-1:0]       r_sync [SYNC_STAGES];
  logic [N-1:0]       r_hist;
  logic [SYNC_STAGES:0] r_arm;
  logic [N-1:0]       r_pend;
  logic [N-1:0]       r_ovf;
  logic [0:0]         r_state;
  logic               r_valid;
  logic [IDW-1:0]     r_id;

  logic               w_armed;
  logic [N-1:0]       w_sync;
  logic [N-1:0]       w_edge;
  logic               w_ack;
  logic [N-1:0]       w_clr;
  logic [N-1:0]       w_pend_out;
  logic               w_any;
  logic [IDW-1:0]     w_top;

  // Synchroniser chain per request line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // History resets to 0, so the chain filling with a line that was already
  // high would look like an edge. Edges are ignored until the chain and the
  // history flop have both been refilled after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_arm  <= '0;
    end else begin
      r_hist <= w_sync;
      r_arm  <= {r_arm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_armed = r_arm[SYNC_STAGES];
  assign w_edge  = {N{w_armed}} & w_sync & ~r_hist;

  assign w_ack = r_valid & irq.irq_ready;

  always_comb begin
    w_clr = '0;
    if (w_ack) begin
      w_clr[r_id] = 1'b1;
    end
  end

  // Set wins over a same-cycle clear so a fresh event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_edge;
    end
  end

  // Overrun: a second edge on a line still pending and not being retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~{N{ovf_clr}})
             | (w_edge & r_pend & ~w_clr);
    end
  end

  assign w_pend_out = r_pend & ~mask;
  assign pend_out   = w_pend_out;
  assign ovf        = r_ovf;

  // MSB-first priority: the highest set bit wins.
  always_comb begin
    w_top = '0;
    w_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_pend_out[i]) begin
        w_top = IDW'(i);
        w_any = 1'b1;
      end
    end
  end

  // Offer FSM. Priority is only re-evaluated in IDLE, so an offered
  // index is never retracted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_top;
            r_valid <= 1'b1;
            r_state <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (irq.irq_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign irq.irq_valid = r_valid;
  assign irq.irq_id    = r_id;

endmodule

// File: tb/tb_irq_request_latch.sv
// tb_irq_request_latch: scenario tasks with a scoreboard of expected
// accepted indices, popped and compared at each accept.
module tb_irq_request_latch;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic [N-1:0] req_in  = '0;
  logic [N-1:0] mask    = '0;
  logic         ovf_clr = 1'b0;
  logic [N-1:0] pend_out;
  logic [N-1:0] ovf;

  int n_pass  = 0;
  int n_total = 0;

  logic [IDW-1:0] exp_q [$];

  always #5 clk = ~clk;

  irq_request_latch_if #(.IDW(IDW)) bus ();

  irq_request_latch #(
    .N(N),
    .IDW(IDW),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_in(req_in),
    .mask(mask),
    .pend_out(pend_out),
    .ovf(ovf),
    .ovf_clr(ovf_clr),
    .irq(bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_offer(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.irq_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_in = '0;
    mask = '0;
    ovf_clr = 1'b0;
    bus.irq_ready = 1'b0;
    #3;
    n_total++;
    if ({pend_out, bus.irq_valid, ovf, bus.irq_id} !== '0)
      $display("FAIL reset_hold got pend=%b v=%b ovf=%b id=%0d want 0",
               pend_out, bus.irq_valid, ovf, bus.irq_id);
    else n_pass++;
    #9 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if ({pend_out, bus.irq_valid, ovf} !== '0)
        $display("FAIL reset_idle[%0d] got pend=%b v=%b ovf=%b want 0",
                 i, pend_out, bus.irq_valid, ovf);
      else n_pass++;
    end
  endtask

  task automatic test_single;
    logic [IDW-1:0] e;
    req_in[1] = 1'b1;
    exp_q.push_back(IDW'(1));
    tick();
    tick();
    n_total++;
    if (pend_out !== 4'b0000)
      $display("FAIL single_pend_e1 got %b want 0000", pend_out);
    else n_pass++;
    tick();
    n_total++;
    if (pend_out !== 4'b0010 || bus.irq_valid !== 1'b0)
      $display("FAIL single_pend_e2 got pend=%b v=%b want 0010 v=0",
               pend_out, bus.irq_valid);
    else n_pass++;
    tick();
    n_total++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd1)
      $display("FAIL single_offer_e3 got v=%b id=%0d want v=1 id=1",
               bus.irq_valid, bus.irq_id);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if ({bus.irq_valid, bus.irq_id, pend_out} !== {1'b1, 2'd1, 4'b0010})
        $display("FAIL single_hold[%0d] got v=%b id=%0d pend=%b want 1/1/0010",
                 i, bus.irq_valid, bus.irq_id, pend_out);
      else n_pass++;
    end
    bus.irq_ready = 1'b1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_total++;
    if (bus.irq_id !== e)
      $display("FAIL single_accept got id=%0d want %0d", bus.irq_id, e);
    else n_pass++;
    tick();
    bus.irq_ready = 1'b0;
    n_total++;
    if (bus.irq_valid !== 1'b0 || pend_out !== 4'b0000)
      $display("FAIL single_cleared got v=%b pend=%b want v=0 pend=0000",
               bus.irq_valid, pend_out);
    else n_pass++;
    req_in = '0;
    repeat (4) tick();
  endtask

  task automatic test_priority;
    logic [IDW-1:0] e;
    int accepts;
    int b2b;
    bit prev;
    accepts = 0;
    b2b = 0;
    prev = 1'b0;
    bus.irq_ready = 1'b1;
    req_in = 4'b0101;
    exp_q.push_back(IDW'(2));
    exp_q.push_back(IDW'(0));
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.irq_valid === 1'b1) begin
        if (prev) b2b++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_total++;
        if (bus.irq_id !== e)
          $display("FAIL prio_order got id=%0d want %0d", bus.irq_id, e);
        else n_pass++;
        accepts++;
      end
      prev = (bus.irq_valid === 1'b1);
    end
    bus.irq_ready = 1'b0;
    n_total++;
    if (accepts !== 2)
      $display("FAIL prio_accepts got %0d want 2", accepts);
    else n_pass++;
    n_total++;
    if (b2b !== 0)
      $display("FAIL prio_gap got %0d back-to-back offers want 0", b2b);
    else n_pass++;
    n_total++;
    if (pend_out !== 4'b0000)
      $display("FAIL prio_drained got %b want 0000", pend_out);
    else n_pass++;
    req_in = '0;
    repeat (4) tick();
  endtask

  task automatic test_mask_noretract;
    logic [IDW-1:0] e;
    bit ok;
    req_in[0] = 1'b1;
    exp_q.push_back(IDW'(0));
    wait_offer(ok);
    n_total++;
    if (!ok || bus.irq_id !== 2'd0)
      $display("FAIL mask_first got ok=%0d id=%0d want ok=1 id=0", ok, bus.irq_id);
    else n_pass++;
    mask = 4'b0001;
    req_in[3] = 1'b1;
    exp_q.push_back(IDW'(3));
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++;
      if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd0)
        $display("FAIL mask_noretract[%0d] got v=%b id=%0d want v=1 id=0",
                 i, bus.irq_valid, bus.irq_id);
      else n_pass++;
    end
    bus.irq_ready = 1'b1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_total++;
    if (bus.irq_id !== e)
      $display("FAIL mask_accept0 got id=%0d want %0d", bus.irq_id, e);
    else n_pass++;
    tick();
    bus.irq_ready = 1'b0;
    req_in[0] = 1'b0;
    tick();
    tick();
    req_in[0] = 1'b1;
    repeat (4) tick();
    n_total++;
    if (pend_out !== 4'b1000 || bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd3)
      $display("FAIL mask_next got pend=%b v=%b id=%0d want 1000 v=1 id=3",
               pend_out, bus.irq_valid, bus.irq_id);
    else n_pass++;
    bus.irq_ready = 1'b1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_total++;
    if (bus.irq_id !== e)
      $display("FAIL mask_accept3 got id=%0d want %0d", bus.irq_id, e);
    else n_pass++;
    tick();
    bus.irq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (bus.irq_valid !== 1'b0 || pend_out !== 4'b0000)
        $display("FAIL mask_suppress[%0d] got v=%b pend=%b want v=0 pend=0000",
                 i, bus.irq_valid, pend_out);
      else n_pass++;
    end
    mask = '0;
    exp_q.push_back(IDW'(0));
    wait_offer(ok);
    n_total++;
    if (!ok)
      $display("FAIL mask_unmask_timeout got no offer want offer");
    else n_pass++;
    bus.irq_ready = 1'b1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_total++;
    if (bus.irq_id !== e)
      $display("FAIL mask_unmask_id got id=%0d want %0d", bus.irq_id, e);
    else n_pass++;
    tick();
    bus.irq_ready = 1'b0;
    n_total++;
    if (pend_out !== 4'b0000)
      $display("FAIL mask_drained got %b want 0000", pend_out);
    else n_pass++;
    req_in = '0;
    repeat (4) tick();
  endtask

  task automatic test_set_beats_clear;
    logic [IDW-1:0] e;
    bit ok;
    req_in[2] = 1'b1;
    exp_q.push_back(IDW'(2));
    exp_q.push_back(IDW'(2));
    wait_offer(ok);
    n_total++;
    if (!ok)
      $display("FAIL sbc_offer_timeout got no offer want offer");
    else n_pass++;
    req_in[2] = 1'b0;
    tick();
    tick();
    req_in[2] = 1'b1;
    tick();
    tick();
    bus.irq_ready = 1'b1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_total++;
    if (bus.irq_id !== e)
      $display("FAIL sbc_accept got id=%0d want %0d", bus.irq_id, e);
    else n_pass++;
    tick();
    bus.irq_ready = 1'b0;
    n_total++;
    if (pend_out !== 4'b0100 || ovf !== 4'b0000)
      $display("FAIL sbc_kept got pend=%b ovf=%b want 0100/0000", pend_out, ovf);
    else n_pass++;
    wait_offer(ok);
    n_total++;
    if (!ok || bus.irq_id !== 2'd2)
      $display("FAIL sbc_reoffer got ok=%0d id=%0d want ok=1 id=2", ok, bus.irq_id);
    else n_pass++;
    req_in[2] = 1'b0;
    tick();
    tick();
    req_in[2] = 1'b1;
    repeat (3) tick();
    n_total++;
    if (ovf !== 4'b0100)
      $display("FAIL ovf_set got %b want 0100", ovf);
    else n_pass++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_total++;
    if (ovf !== 4'b0000)
      $display("FAIL ovf_clr got %b want 0000", ovf);
    else n_pass++;
    bus.irq_ready = 1'b1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_total++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== e)
      $display("FAIL ovf_accept got v=%b id=%0d want v=1 id=%0d",
               bus.irq_valid, bus.irq_id, e);
    else n_pass++;
    tick();
    bus.irq_ready = 1'b0;
    n_total++;
    if (pend_out !== 4'b0000 || exp_q.size() !== 0)
      $display("FAIL sbc_drained got pend=%b q=%0d want 0000 q=0",
               pend_out, exp_q.size());
    else n_pass++;
    req_in = '0;
    repeat (4) tick();
  endtask

  task automatic test_async_reset;
    bit ok;
    req_in = 4'b0011;
    wait_offer(ok);
    n_total++;
    if (!ok || bus.irq_id !== 2'd1)
      $display("FAIL arst_offer got ok=%0d id=%0d want ok=1 id=1", ok, bus.irq_id);
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.irq_valid !== 1'b0 || pend_out !== 4'b0000 || ovf !== 4'b0000)
      $display("FAIL arst_immediate got v=%b pend=%b ovf=%b want 0/0000/0000",
               bus.irq_valid, pend_out, ovf);
    else n_pass++;
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if (bus.irq_valid !== 1'b0 || pend_out !== 4'b0000)
        $display("FAIL arst_noevent[%0d] got v=%b pend=%b want v=0 pend=0000",
                 i, bus.irq_valid, pend_out);
      else n_pass++;
    end
    req_in = '0;
    repeat (2) tick();
  endtask

  initial begin
    bus.irq_ready = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_mask_noretract();
    test_set_beats_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
